sem_multifase: RTL and testbench



---
 rtl/sem_multifase.sv | 87 ++++++++
 tb/tb_sem_multifase.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sem_multifase.sv
// sem_multifase: multiphase car/pedestrian light controller with latched request, clearance intervals and night flashing
module sem_multifase #(
  parameter int W = 6,
  parameter int T_GREEN_MIN = 30,
  parameter int T_AMBER = 5,
  parameter int T_CLEAR = 2,
  parameter int T_PED = 15,
  parameter int T_PED_FLASH = 5,
  parameter int AUTO_CYCLE = 0
) (
  input logic CLK,
  input logic RST,
  input logic CLK_ENA,
  input logic PED_REQ,
  input logic NIGHT,
  output logic Rcars,
  output logic Gcars,
  output logic Rpedes,
  output logic Gpedes,
  output logic PED_WAIT,
  output logic [2:0] PHASE,
  output logic TC
);
  typedef enum logic [2:0] {CAR_GREEN, CAR_AMBER, ALL_RED1, PED_GREEN, PED_FLASH, ALL_RED2, NIGHT_FLASH} state_t;
  state_t r_state, w_state;
  logic [W-1:0] r_count, w_count, w_dur;
  logic r_blink, w_blink, r_latch, w_last;
  logic [3:0] w_lamps;
  assign PED_WAIT = r_latch;
  always_comb begin
    w_dur = r_state == CAR_AMBER ? W'(T_AMBER) :
            (r_state == ALL_RED1 || r_state == ALL_RED2) ? W'(T_CLEAR) :
            r_state == PED_GREEN ? W'(T_PED) :
            r_state == PED_FLASH ? W'(T_PED_FLASH) : W'(T_GREEN_MIN);
    w_last = r_count == w_dur - 1'b1;
    w_state = r_state;
    w_count = r_count;
    if (CLK_ENA)
      case (r_state)
        CAR_GREEN:
          if (NIGHT) begin
            w_state = NIGHT_FLASH;
            w_count = '0;
          end else if (!w_last) w_count = r_count + 1'b1;
          else if (r_latch || AUTO_CYCLE != 0) begin
            w_state = CAR_AMBER;
            w_count = '0;
          end
        NIGHT_FLASH: begin
          w_count = '0;
          if (!NIGHT) w_state = ALL_RED2;
        end
        default:
          if (!w_last) w_count = r_count + 1'b1;
          else begin
            w_state = r_state == ALL_RED2 ? CAR_GREEN : state_t'(r_state + 3'd1);
            w_count = '0;
          end
      endcase
    // blink is 0 on the entry edge and toggles on each tick spent in a flashing state
    w_blink = (r_state == PED_FLASH || r_state == NIGHT_FLASH) ? r_blink ^ CLK_ENA : 1'b0;
    w_lamps = w_state == CAR_GREEN ? 4'b0110 :
              w_state == CAR_AMBER ? 4'b1110 :
              w_state == PED_GREEN ? 4'b1001 :
              w_state == PED_FLASH ? {3'b100, w_blink} :
              w_state == NIGHT_FLASH ? {w_blink, w_blink, 2'b00} : 4'b1010;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= CAR_GREEN;
      r_count <= '0;
      r_blink <= 1'b0;
      r_latch <= 1'b0;
      {Rcars, Gcars, Rpedes, Gpedes} <= 4'b0110;
      PHASE <= 3'd0;
      TC <= 1'b0;
    end else begin
      r_state <= w_state;
      r_count <= w_count;
      r_blink <= w_blink;
      r_latch <= (w_state == NIGHT_FLASH || (w_state == PED_GREEN && r_state != PED_GREEN)) ? 1'b0 : r_latch | PED_REQ;
      {Rcars, Gcars, Rpedes, Gpedes} <= w_lamps;
      PHASE <= w_state;
      TC <= r_state == ALL_RED2 && w_state == CAR_GREEN;
    end
  end
endmodule

// File: tb/tb_sem_multifase.sv
// tb_sem_multifase: directed scenario checks of sem_multifase with default and short auto-cycling parameters
module tb_sem_multifase;
  logic clk = 1'b0, rst = 1'b0, ena = 1'b0, req = 1'b0, night = 1'b0;
  logic rc, gc, rp, gp, wt, tc, a_rc, a_gc, a_rp, a_gp, a_wt, a_tc;
  logic [2:0] ph, a_ph;
  int checks = 0, errors = 0, tick_no = 0;
  always #5 clk = ~clk;
  sem_multifase dut (
    .CLK(clk), .RST(rst), .CLK_ENA(ena), .PED_REQ(req), .NIGHT(night),
    .Rcars(rc), .Gcars(gc), .Rpedes(rp), .Gpedes(gp), .PED_WAIT(wt), .PHASE(ph), .TC(tc)
  );
  sem_multifase #(.W(4), .T_GREEN_MIN(3), .T_AMBER(1), .T_CLEAR(1), .AUTO_CYCLE(1)) dut_auto (
    .CLK(clk), .RST(rst), .CLK_ENA(ena), .PED_REQ(1'b0), .NIGHT(1'b0),
    .Rcars(a_rc), .Gcars(a_gc), .Rpedes(a_rp), .Gpedes(a_gp), .PED_WAIT(a_wt), .PHASE(a_ph), .TC(a_tc)
  );
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; ena = 1'b0; req = 1'b0; night = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick_no = 0;
  endtask
  task automatic tick;
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    tick_no++;
  endtask
  task automatic advance(input int target);
    while (tick_no < target) tick();
  endtask
  task automatic test_reset;
    do_reset();
    if ({rc, gc, rp, gp, wt, ph, tc} !== 9'b0110_0_000_0) begin
      errors++; $display("FAIL reset got %b exp 011000000", {rc, gc, rp, gp, wt, ph, tc});
    end
    checks++;
  endtask
  task automatic test_idle;
    int bad = 0;
    do_reset();
    repeat (100) begin
      tick();
      if (tc !== 1'b0 || ph !== 3'd0 || {rc, gc, rp, gp} !== 4'b0110) bad++;
    end
    if (bad !== 0) begin
      errors++; $display("FAIL idle got %0d bad ticks exp 0", bad);
    end
    checks++;
  endtask
  task automatic test_ped_cycle;
    do_reset();
    advance(2);
    req = 1'b1;
    tick();
    req = 1'b0;
    if (wt !== 1'b1) begin
      errors++; $display("FAIL ped_wait_set got %b exp 1", wt);
    end
    checks++;
    advance(29);
    if (ph !== 3'd0) begin
      errors++; $display("FAIL green@29 got phase %0d exp 0", ph);
    end
    checks++;
    advance(30);
    if ({rc, gc, rp, gp} !== 4'b1110 || ph !== 3'd1) begin
      errors++; $display("FAIL amber@30 got %b/%0d exp 1110/1", {rc, gc, rp, gp}, ph);
    end
    checks++;
    advance(35);
    if ({rc, gc, rp, gp} !== 4'b1010 || ph !== 3'd2) begin
      errors++; $display("FAIL allred1@35 got %b/%0d exp 1010/2", {rc, gc, rp, gp}, ph);
    end
    checks++;
    advance(37);
    if ({rc, gc, rp, gp, wt} !== 5'b10010 || ph !== 3'd3) begin
      errors++; $display("FAIL pedgreen@37 got %b/%0d exp 10010/3", {rc, gc, rp, gp, wt}, ph);
    end
    checks++;
    advance(52);
    if ({rc, gc, rp, gp} !== 4'b1000 || ph !== 3'd4) begin
      errors++; $display("FAIL pedflash@52 got %b/%0d exp 1000/4", {rc, gc, rp, gp}, ph);
    end
    checks++;
    advance(53);
    if (gp !== 1'b1) begin
      errors++; $display("FAIL flash_on@53 got %b exp 1", gp);
    end
    checks++;
    advance(54);
    if (gp !== 1'b0) begin
      errors++; $display("FAIL flash_off@54 got %b exp 0", gp);
    end
    checks++;
    advance(58);
    if ({rc, gc, rp, gp} !== 4'b1010 || ph !== 3'd5 || tc !== 1'b0) begin
      errors++; $display("FAIL allred2@58 got %b/%0d/%b exp 1010/5/0", {rc, gc, rp, gp}, ph, tc);
    end
    checks++;
    advance(59);
    if ({rc, gc, rp, gp} !== 4'b0110 || ph !== 3'd0 || tc !== 1'b1) begin
      errors++; $display("FAIL cycle_end@59 got %b/%0d/%b exp 0110/0/1", {rc, gc, rp, gp}, ph, tc);
    end
    checks++;
    @(negedge clk);
    if (tc !== 1'b0) begin
      errors++; $display("FAIL tc_width got %b exp 0", tc);
    end
    checks++;
  endtask
  task automatic test_back_to_back;
    do_reset();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    advance(36);
    req = 1'b1;
    tick();
    if (wt !== 1'b0 || ph !== 3'd3) begin
      errors++; $display("FAIL clear_wins got %b/%0d exp 0/3", wt, ph);
    end
    checks++;
    @(negedge clk);
    req = 1'b0;
    if (wt !== 1'b1) begin
      errors++; $display("FAIL held_req got %b exp 1", wt);
    end
    checks++;
    advance(88);
    if (ph !== 3'd0) begin
      errors++; $display("FAIL second_green@88 got %0d exp 0", ph);
    end
    checks++;
    advance(89);
    if (ph !== 3'd1) begin
      errors++; $display("FAIL second_amber@89 got %0d exp 1", ph);
    end
    checks++;
  endtask
  task automatic test_night;
    do_reset();
    advance(9);
    night = 1'b1;
    tick();
    if ({rc, gc, rp, gp} !== 4'b0000 || ph !== 3'd6) begin
      errors++; $display("FAIL night@10 got %b/%0d exp 0000/6", {rc, gc, rp, gp}, ph);
    end
    checks++;
    tick();
    if ({rc, gc, rp, gp} !== 4'b1100) begin
      errors++; $display("FAIL night@11 got %b exp 1100", {rc, gc, rp, gp});
    end
    checks++;
    req = 1'b1;
    tick();
    req = 1'b0;
    if ({rc, gc, rp, gp, wt} !== 5'b00000) begin
      errors++; $display("FAIL night@12 got %b exp 00000", {rc, gc, rp, gp, wt});
    end
    checks++;
    tick();
    if ({rc, gc, rp, gp} !== 4'b1100) begin
      errors++; $display("FAIL night@13 got %b exp 1100", {rc, gc, rp, gp});
    end
    checks++;
    night = 1'b0;
    tick();
    if ({rc, gc, rp, gp} !== 4'b1010 || ph !== 3'd5 || tc !== 1'b0) begin
      errors++; $display("FAIL night_exit@14 got %b/%0d/%b exp 1010/5/0", {rc, gc, rp, gp}, ph, tc);
    end
    checks++;
    advance(15);
    if (ph !== 3'd5) begin
      errors++; $display("FAIL night_allred@15 got %0d exp 5", ph);
    end
    checks++;
    advance(16);
    if (ph !== 3'd0 || tc !== 1'b1 || {rc, gc, rp, gp} !== 4'b0110) begin
      errors++; $display("FAIL night_return@16 got %0d/%b/%b exp 0/1/0110", ph, tc, {rc, gc, rp, gp});
    end
    checks++;
  endtask
  task automatic test_night_in_ped;
    do_reset();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    advance(40);
    night = 1'b1;
    advance(52);
    if (ph !== 3'd4) begin
      errors++; $display("FAIL np_flash@52 got %0d exp 4", ph);
    end
    checks++;
    advance(57);
    if (ph !== 3'd5) begin
      errors++; $display("FAIL np_allred2@57 got %0d exp 5", ph);
    end
    checks++;
    advance(59);
    if (ph !== 3'd0 || tc !== 1'b1) begin
      errors++; $display("FAIL np_green@59 got %0d/%b exp 0/1", ph, tc);
    end
    checks++;
    advance(60);
    if (ph !== 3'd6) begin
      errors++; $display("FAIL np_night@60 got %0d exp 6", ph);
    end
    checks++;
    night = 1'b0;
  endtask
  task automatic test_mid_reset;
    do_reset();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    advance(54);
    if (ph !== 3'd4) begin
      errors++; $display("FAIL pre_rst@54 got %0d exp 4", ph);
    end
    checks++;
    req = 1'b1;
    rst = 1'b1;
    ena = 1'b1;
    @(negedge clk);
    rst = 1'b0; ena = 1'b0; req = 1'b0;
    tick_no = 0;
    if ({rc, gc, rp, gp, wt, ph, tc} !== 9'b0110_0_000_0) begin
      errors++; $display("FAIL mid_reset got %b exp 011000000", {rc, gc, rp, gp, wt, ph, tc});
    end
    checks++;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    advance(29);
    if (ph !== 3'd0) begin
      errors++; $display("FAIL post_rst@29 got %0d exp 0", ph);
    end
    checks++;
    advance(30);
    if (ph !== 3'd1) begin
      errors++; $display("FAIL post_rst@30 got %0d exp 1", ph);
    end
    checks++;
  endtask
  task automatic test_auto_cycle;
    do_reset();
    advance(2);
    if (a_ph !== 3'd0) begin
      errors++; $display("FAIL auto@2 got %0d exp 0", a_ph);
    end
    checks++;
    advance(3);
    if (a_ph !== 3'd1 || {a_rc, a_gc, a_rp, a_gp} !== 4'b1110) begin
      errors++; $display("FAIL auto@3 got %0d/%b exp 1/1110", a_ph, {a_rc, a_gc, a_rp, a_gp});
    end
    checks++;
    advance(5);
    if (a_ph !== 3'd3) begin
      errors++; $display("FAIL auto@5 got %0d exp 3", a_ph);
    end
    checks++;
    advance(25);
    if (a_ph !== 3'd5 || a_tc !== 1'b0) begin
      errors++; $display("FAIL auto@25 got %0d/%b exp 5/0", a_ph, a_tc);
    end
    checks++;
    advance(26);
    if (a_ph !== 3'd0 || a_tc !== 1'b1) begin
      errors++; $display("FAIL auto@26 got %0d/%b exp 0/1", a_ph, a_tc);
    end
    checks++;
    advance(51);
    if (a_ph !== 3'd5 || a_tc !== 1'b0) begin
      errors++; $display("FAIL auto@51 got %0d/%b exp 5/0", a_ph, a_tc);
    end
    checks++;
    advance(52);
    if (a_ph !== 3'd0 || a_tc !== 1'b1) begin
      errors++; $display("FAIL auto@52 got %0d/%b exp 0/1", a_ph, a_tc);
    end
    checks++;
  endtask
  initial begin
    test_reset();
    test_idle();
    test_ped_cycle();
    test_back_to_back();
    test_night();
    test_night_in_ped();
    test_mid_reset();
    test_auto_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
